// File: rtl/uart_receiver.sv
// UART receiver for asynchronous frames: one start bit, D data bits sent LSB
// first, and a stop bit, sampled on an OS-times oversampling tick.
// A two-flop synchronizer feeds a four-state FSM (IDLE/START/DATA/STOP).
// The finished word comes out with a one-cycle done strobe and a framing-error flag.
module uart_receiver #(
  parameter int D       = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_in,
  input  logic         baud_clk,
  output logic [D-1:0] data,
  output logic         rx_done,
  output logic         frame_err
);

  localparam int SMAX = ((OS > SB_TICK) ? OS : SB_TICK) - 1;
  localparam int SW   = (SMAX > 0) ? $clog2(SMAX + 1) : 1;
  localparam int NW   = (D > 1) ? $clog2(D) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(D - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [NW-1:0]   n, n_nxt;
  logic [D-1:0]    sh, sh_nxt;
  logic [D-1:0]    data_nxt;
  logic            done_nxt, err_nxt;
  logic            stop_hit;

  // Stage p0/p1: two-flop synchronizer; the line idles high, so reset to 1
  logic rx_sync_p0, rx_s;

  // Bring the asynchronous serial line into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_in;
      rx_s       <= rx_sync_p0;
    end
  end

  // Stop bit is judged on the last stop-phase tick
  assign stop_hit = (state == STOP) && baud_clk && (s == S_STOP);

  // State register together with counters, shift register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      sh        <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      n         <= n_nxt;
      sh        <= sh_nxt;
      data      <= data_nxt;
      rx_done   <= done_nxt;
      frame_err <= err_nxt;
    end
  end

  // Next-state logic: counters move only on baud ticks; start detection does not wait for one
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    sh_nxt    = sh;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end
      START: begin
        if (baud_clk) begin
          if (s == S_HALF) begin
            s_nxt = '0;
            if (!rx_s) begin
              state_nxt = DATA;
              n_nxt     = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_clk) begin
          if (s == S_BIT) begin
            s_nxt  = '0;
            sh_nxt = {rx_s, sh[D-1:1]};
            if (n == N_LAST) begin
              state_nxt = STOP;
            end else begin
              n_nxt = n + 1'b1;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_clk) begin
          if (s == S_STOP) begin
            s_nxt     = '0;
            state_nxt = IDLE;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: publish the word and one-cycle strobes when the stop bit is judged
  always_comb begin
    done_nxt = stop_hit;
    err_nxt  = stop_hit & ~rx_s;
    data_nxt = stop_hit ? sh : data;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver. A tick generator stands in for the baud-rate
// generator. Frames are built on the serial line from bytes and stop bits.
// Each received word is checked against the byte that was sent on the line.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int D          = 8;
  localparam int OS         = 16;
  localparam int SB_TICK    = 16;
  localparam int CLK_PERIOD = 10;
  localparam int TDIV       = 4;          // clk cycles per oversample tick
  localparam int BIT        = OS * TDIV;  // clk cycles per bit

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         rx_in    = 1'b1;
  logic         baud_clk = 1'b0;
  logic [D-1:0] data;
  logic         rx_done;
  logic         frame_err;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  typedef struct {
    logic [D-1:0] d;
    logic         e;
    longint       t;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  uart_receiver #(.D(D), .OS(OS), .SB_TICK(SB_TICK)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .baud_clk  (baud_clk),
    .data      (data),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #(CLK_PERIOD/2) clk = ~clk;

  // Oversample tick: one clk wide, every TDIV clocks
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (tc == TDIV - 1) begin
        tc = 0;
        baud_clk <= 1'b1;
      end else begin
        tc = tc + 1;
        baud_clk <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Record every completed frame and check that the strobes are single-cycle
  initial begin
    ev_t  ev;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done === 1'b1) begin
        ev.d = data;
        ev.e = frame_err;
        ev.t = cyc;
        obs_q.push_back(ev);
        chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      end
      if (frame_err === 1'b1) chk("err_with_done", {31'd0, rx_done}, 32'd1);
      prev_done = rx_done;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; a low stop bit is held for 3/4 bit, then the line idles 2 bits
  task automatic send_frame(input logic [D-1:0] b, input logic stop, output longint t_edge);
    ev_t x;
    x.d = b;
    x.e = ~stop;
    x.t = 0;
    exp_q.push_back(x);
    @(negedge clk);
    t_edge = cyc;
    rx_in = 1'b0;
    wait_clk(BIT - 1);
    for (int i = 0; i < D; i++) begin
      rx_in = b[i];
      wait_clk(BIT);
    end
    rx_in = stop;
    wait_clk(stop ? BIT : (BIT * 3) / 4);
    rx_in = 1'b1;
    if (!stop) wait_clk(2 * BIT);
  endtask

  // Wait for the expected frames, allow time for extras, then compare in order
  task automatic drain(input string tag);
    int  budget;
    ev_t x;
    ev_t o;
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 12 * BIT) begin
      @(negedge clk);
      budget++;
    end
    wait_clk(2 * BIT);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        chk({tag, "_data"}, {24'd0, o.d}, {24'd0, x.d});
        chk({tag, "_err"},  {31'd0, o.e}, {31'd0, x.e});
      end
    end
    obs_q.delete();
  endtask

  initial begin
    longint       t0;
    longint       lat;
    logic [D-1:0] rb;
    logic         rs;

    // Reset state
    wait_clk(5);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_done", {31'd0, rx_done}, 32'd0);
    chk("reset_err",  {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    wait_clk(BIT);

    // Single frame and its latency from the start edge
    send_frame(8'h41, 1'b1, t0);
    wait_clk(BIT);
    lat = (obs_q.size() > 0) ? (obs_q[0].t - t0) : -1;
    chk("latency_window",
        {31'd0, (lat >= (19 * BIT) / 2 - TDIV) && (lat <= (19 * BIT) / 2 + 3 * TDIV)}, 32'd1);
    drain("single");

    // Back-to-back frames with no idle gap
    send_frame(8'h41, 1'b1, t0);
    send_frame(8'h42, 1'b1, t0);
    send_frame(8'h43, 1'b1, t0);
    send_frame(8'h44, 1'b1, t0);
    send_frame(8'h45, 1'b1, t0);
    drain("b2b");

    // Glitch shorter than half a bit, then a good frame
    rx_in = 1'b0;
    wait_clk(3 * TDIV);
    rx_in = 1'b1;
    wait_clk(2 * BIT);
    chk("glitch_no_frame", obs_q.size(), 32'd0);
    send_frame(8'hA5, 1'b1, t0);
    drain("after_glitch");

    // Framing error
    send_frame(8'h55, 1'b0, t0);
    drain("frame_err");

    // Random bytes and random stop bits
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(3) != 0);
      send_frame(rb, rs, t0);
    end
    drain("random");

    // Reset in the middle of data bit 4 of 8'hFF
    @(negedge clk);
    rx_in = 1'b0;
    wait_clk(BIT);
    rx_in = 1'b1;
    wait_clk(4 * BIT + BIT / 2);
    reset = 1'b1;
    #1;
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_done", {31'd0, rx_done}, 32'd0);
    chk("midrst_err",  {31'd0, frame_err}, 32'd0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(6 * BIT);
    chk("midrst_no_pulse", obs_q.size(), 32'd0);
    send_frame(8'h3C, 1'b1, t0);
    drain("after_reset");

    // Break: line low for 12 bit times, then idle
    rx_in = 1'b0;
    wait_clk(12 * BIT);
    rx_in = 1'b1;
    wait_clk(14 * BIT);
    chk("break_count", obs_q.size(), 32'd2);
    if (obs_q.size() > 0) begin
      chk("break_data", {24'd0, obs_q[0].d}, 32'd0);
      chk("break_err",  {31'd0, obs_q[0].e}, 32'd1);
    end
    if (obs_q.size() > 1) chk("break_tail_err", {31'd0, obs_q[1].e}, 32'd0);
    obs_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
